// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) encoder/corrector pair: widths, bit layout, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package hamming_pkg;

    localparam int LARG_DADO    = 11;
    localparam int LARG_PALAVRA = 15;

    // Codeword index receiving each data bit d[i]
    localparam int MAPA_DADO [LARG_DADO] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    // Codeword index of each parity bit and the indices it covers
    localparam int POS_PARIDADE [4] = '{0, 1, 3, 7};
    localparam int LISTA_PARIDADE [4][7] = '{
        '{2, 4, 6, 8, 10, 12, 14},
        '{2, 5, 6, 9, 10, 13, 14},
        '{4, 5, 6, 11, 12, 13, 14},
        '{8, 9, 10, 11, 12, 13, 14}
    };

    typedef enum logic [1:0] {OCIOSO, START, DADOS, STOP} estado_t;

    // Error-injection mask: 0 -> no flip, v in 1..15 -> flip codeword bit v-1
    function automatic logic [LARG_PALAVRA-1:0] mascara_erro(input logic [3:0] v);
        return LARG_PALAVRA'((16'd1 << v) >> 1);
    endfunction

endpackage

// File: rtl/codifica_hamming.sv
// Purely combinational Hamming(15,11) encoder using the corrector's bit layout.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows input.
module codifica_hamming
    import hamming_pkg::*;
(
    input  logic [LARG_DADO-1:0]    dado,
    output logic [LARG_PALAVRA-1:0] palavra
);

    logic paridade;

    // Place data bits, then fill each parity position from the bits it covers
    always_comb begin
        paridade = 1'b0;
        palavra  = '0;
        for (int i = 0; i < LARG_DADO; i++) begin
            palavra[MAPA_DADO[i]] = dado[i];
        end
        for (int p = 0; p < 4; p++) begin
            paridade = 1'b0;
            for (int k = 0; k < 7; k++) begin
                paridade = paridade ^ palavra[LISTA_PARIDADE[p][k]];
            end
            palavra[POS_PARIDADE[p]] = paridade;
        end
    end

endmodule

// File: rtl/codifica_hamming_serial.sv
// Encodes 11-bit words into Hamming(15,11) and sends start + 15 bits LSB first + stop on a serial line.
// Latency: line drops on the acceptance edge; frame is 17*CICLOS_POR_BIT cycles until pronto returns.
// Backpressure: pronto low for the whole frame; dado_valido while busy is ignored (no queuing).
module codifica_hamming_serial
    import hamming_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LARG_DADO-1:0]    dado,
    input  logic                    dado_valido,
    input  logic [3:0]              injeta_erro,
    output logic                    pronto,
    output logic [LARG_PALAVRA-1:0] palavra,
    output logic                    linha_tx,
    output logic                    ocupado
);

    localparam logic [15:0] CB_FIM = 16'(CICLOS_POR_BIT - 1);

    estado_t                 estado;
    logic [15:0]             cb;
    logic [3:0]              nb;
    logic [LARG_PALAVRA-1:0] shift;
    logic [LARG_PALAVRA-1:0] cw;
    logic [LARG_PALAVRA-1:0] cw_inj;
    logic                    fim_bit;

    codifica_hamming u_codifica (
        .dado    (dado),
        .palavra (cw)
    );

    assign cw_inj  = cw ^ mascara_erro(injeta_erro);
    assign fim_bit = (cb == CB_FIM);
    assign pronto  = (estado == OCIOSO);
    assign ocupado = ~pronto;

    // Frame FSM: baud counter, bit counter, shift register and registered line/codeword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            linha_tx <= 1'b1;
            palavra  <= '0;
            shift    <= '0;
            cb       <= '0;
            nb       <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    linha_tx <= 1'b1;
                    cb       <= '0;
                    nb       <= '0;
                    if (dado_valido) begin
                        palavra  <= cw_inj;
                        shift    <= cw_inj;
                        estado   <= START;
                        linha_tx <= 1'b0;
                    end
                end
                START: begin
                    if (fim_bit) begin
                        cb       <= '0;
                        nb       <= '0;
                        estado   <= DADOS;
                        linha_tx <= shift[0];
                    end else begin
                        cb <= cb + 16'd1;
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        cb <= '0;
                        if (nb == 4'd14) begin
                            estado   <= STOP;
                            linha_tx <= 1'b1;
                        end else begin
                            shift    <= {1'b0, shift[LARG_PALAVRA-1:1]};
                            linha_tx <= shift[1];
                            nb       <= nb + 4'd1;
                        end
                    end else begin
                        cb <= cb + 16'd1;
                    end
                end
                STOP: begin
                    if (fim_bit) begin
                        cb     <= '0;
                        estado <= OCIOSO;
                    end else begin
                        cb <= cb + 16'd1;
                    end
                end
                default: begin
                    estado   <= OCIOSO;
                    linha_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codifica_hamming_serial.sv
// Self-checking bench for codifica_hamming_serial against a positional Hamming reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_codifica_hamming_serial;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dado = '0;
    logic        dado_valido = 1'b0;
    logic [3:0]  injeta_erro = '0;
    logic        pronto;
    logic [14:0] palavra;
    logic        linha_tx;
    logic        ocupado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    codifica_hamming_serial #(.CICLOS_POR_BIT(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dado        (dado),
        .dado_valido (dado_valido),
        .injeta_erro (injeta_erro),
        .pronto      (pronto),
        .palavra     (palavra),
        .linha_tx    (linha_tx),
        .ocupado     (ocupado)
    );

    // Classic Hamming: parity at power-of-two positions, data fills the rest in order,
    // parity at 2^k covers every position with bit k set.
    function automatic logic [14:0] modelo(input logic [10:0] d, input logic [3:0] e);
        logic [14:0] w;
        int          dp;
        logic        p;
        w  = '0;
        dp = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos-1] = d[dp];
                dp++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if (((pos >> k) & 1) == 1 && (pos & (pos - 1)) != 0) p = p ^ w[pos-1];
            end
            w[(1 << k) - 1] = p;
        end
        if (e != 4'd0) w[e - 4'd1] = ~w[e - 4'd1];
        return w;
    endfunction

    // Syndrome = xor of the positions of all set bits; equals the flipped position
    function automatic logic [3:0] sindrome(input logic [14:0] w);
        logic [3:0] s;
        s = '0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (w[pos-1]) s = s ^ 4'(pos);
        end
        return s;
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for pronto, present a word, return just after the acceptance edge
    task automatic aceita(input logic [10:0] d, input logic [3:0] e, input bit manter);
        int espera;
        espera = 0;
        @(negedge clk);
        while (!pronto && espera < 200) begin
            @(negedge clk);
            espera++;
        end
        if (!pronto) verifica("timeout_pronto", 32'(pronto), 32'd1);
        dado        = d;
        injeta_erro = e;
        dado_valido = 1'b1;
        @(posedge clk);
        #1;
        if (!manter) dado_valido = 1'b0;
    endtask

    // Check the serial waveform cycle by cycle; a full-length call also checks the return to idle
    task automatic quadro(input logic [14:0] cw, input int ncic);
        int   j;
        logic esperado;
        for (int i = 0; i < ncic; i++) begin
            @(negedge clk);
            j = i / N;
            if (j == 0)       esperado = 1'b0;
            else if (j == 16) esperado = 1'b1;
            else              esperado = cw[j-1];
            verifica("linha_tx_bit", 32'(linha_tx), 32'(esperado));
            verifica("palavra_mantida", 32'(palavra), 32'(cw));
            verifica("pronto_ocupado", 32'(pronto), 32'd0);
            verifica("ocupado_quadro", 32'(ocupado), 32'd1);
        end
        if (ncic == 17 * N) begin
            @(negedge clk);
            verifica("pronto_volta", 32'(pronto), 32'd1);
            verifica("ocupado_fim", 32'(ocupado), 32'd0);
            verifica("linha_ociosa", 32'(linha_tx), 32'd1);
        end
    endtask

    logic [10:0] dir_dado [4] = '{11'h001, 11'h400, 11'h7FF, 11'h000};
    logic [14:0] dir_cw   [4] = '{15'h0007, 15'h408B, 15'h7FFF, 15'h0000};

    initial begin
        logic [10:0] da;
        logic [10:0] db;
        logic [3:0]  e;
        logic [14:0] cwa;
        logic [14:0] cwb;

        // Reset then idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            verifica("idle_pronto", 32'(pronto), 32'd1);
            verifica("idle_linha", 32'(linha_tx), 32'd1);
            verifica("idle_palavra", 32'(palavra), 32'h0);
            verifica("idle_ocupado", 32'(ocupado), 32'd0);
        end

        // Directed encodes with full frame timing
        for (int t = 0; t < 4; t++) begin
            aceita(dir_dado[t], 4'd0, 1'b0);
            verifica("palavra_dir", 32'(palavra), 32'(dir_cw[t]));
            verifica("palavra_modelo", 32'(palavra), 32'(modelo(dir_dado[t], 4'd0)));
            quadro(dir_cw[t], 17 * N);
        end

        // Injection on bit 14
        aceita(11'h001, 4'd15, 1'b0);
        verifica("palavra_injeta", 32'(palavra), 32'h4007);
        verifica("sindrome_injeta", 32'(sindrome(palavra)), 32'd15);
        quadro(15'h4007, 17 * N);

        // Random words and injections
        for (int r = 0; r < 8; r++) begin
            da = 11'($urandom);
            e  = 4'($urandom_range(0, 15));
            aceita(da, e, 1'b0);
            cwa = modelo(da, e);
            verifica("palavra_rand", 32'(palavra), 32'(cwa));
            verifica("sindrome_rand", 32'(sindrome(palavra)), 32'(e));
            quadro(cwa, 17 * N);
        end

        // Busy and back-to-back: valid held high with new data during a frame
        da = 11'($urandom);
        db = da ^ 11'h5A5;
        cwa = modelo(da, 4'd0);
        cwb = modelo(db, 4'd0);
        aceita(da, 4'd0, 1'b1);
        dado = db;
        quadro(cwa, 17 * N);
        @(posedge clk);
        #1;
        dado_valido = 1'b0;
        verifica("palavra_b2b", 32'(palavra), 32'(cwb));
        quadro(cwb, 17 * N);

        // Reset mid-frame during data bit 7 (cw[7]=0 here, so the line is low beforehand)
        aceita(11'h001, 4'd0, 1'b0);
        quadro(15'h0007, 8 * N + 2);
        #2;
        rst_n = 1'b0;
        #1;
        verifica("rst_async_linha", 32'(linha_tx), 32'd1);
        verifica("rst_async_pronto", 32'(pronto), 32'd1);
        verifica("rst_async_ocupado", 32'(ocupado), 32'd0);
        verifica("rst_async_palavra", 32'(palavra), 32'h0);
        repeat (2) @(negedge clk);
        verifica("rst_linha_mantida", 32'(linha_tx), 32'd1);
        rst_n = 1'b1;
        da = 11'($urandom);
        cwa = modelo(da, 4'd0);
        aceita(da, 4'd0, 1'b0);
        verifica("palavra_pos_rst", 32'(palavra), 32'(cwa));
        quadro(cwa, 17 * N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codifica_hamming_serial.md
Name: codifica_hamming_serial

Overview:
Upstream stage of the Hamming(15,11) corrector. It accepts 11-bit data words over a valid/ready handshake and encodes each into a 15-bit codeword whose bit layout is exactly the one the corrector decodes. The codeword is sent on a UART-like serial line: start bit, 15 codeword bits, stop bit. A registered copy of the codeword is also exposed in parallel. Optional single-bit error injection lets the downstream corrector be exercised on real traffic.

Parameters:
CICLOS_POR_BIT, 4, clock cycles per serial bit; legal range 1..65535.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
dado  input  11  data word to encode
dado_valido  input  1  dado is valid
injeta_erro  input  4  0 = no error; v in 1..15 flips codeword bit v-1; sampled with dado
pronto  output  1  block can accept a word; equals (estado == OCIOSO)
palavra  output  15  registered codeword of the last accepted word, including any injected error
linha_tx  output  1  serial line; idles high
ocupado  output  1  high while a frame is in progress; equals ~pronto

Behaviour:
- Reset, async on rst_n low: estado=OCIOSO, linha_tx=1, palavra=0, internal counters=0, so pronto=1 and ocupado=0. Reset mid-frame aborts the frame and drives the line high immediately. No partial frame resumes after reset.
- Codeword layout (index = position-1):
  - Data map: d[0]->cw[2], d[1]->cw[4], d[2]->cw[5], d[3]->cw[6], d[10:4]->cw[14:8].
  - cw[0] = xor of cw[2,4,6,8,10,12,14].
  - cw[1] = xor of cw[2,5,6,9,10,13,14].
  - cw[3] = xor of cw[4,5,6,11,12,13,14].
  - cw[7] = xor of cw[14:8].
  - Encoding is combinational on dado and is captured at acceptance.
- Handshake: a transfer occurs on a rising edge where dado_valido && pronto.
  - At that edge: palavra <= cw ^ (injeta_erro != 0 ? 1 << (injeta_erro-1) : 0); the shift register loads the same value; estado <= START; linha_tx <= 0.
  - dado_valido while busy is ignored, with no queuing. The producer must hold dado until pronto.
- FSM, with baud counter cb (0..CICLOS_POR_BIT-1) and bit counter nb (0..14):
  - OCIOSO: linha_tx=1. On transfer go to START.
  - START: linha_tx=0 for CICLOS_POR_BIT cycles. At cb terminal, go to DADOS with nb=0 and linha_tx=cw[0].
  - DADOS: linha_tx=shift[0] for CICLOS_POR_BIT cycles per bit, LSB first. At cb terminal: if nb==14, go to STOP with linha_tx=1; else shift right and nb++.
  - STOP: linha_tx=1 for CICLOS_POR_BIT cycles. At cb terminal, go to OCIOSO.
- Timing:
  - Frame length is exactly 17*CICLOS_POR_BIT cycles from the acceptance edge to re-entry into OCIOSO.
  - The next acceptance can occur on the first edge in OCIOSO, so the minimum gap is 1 idle cycle between frames.
- CICLOS_POR_BIT=1: every state lasts one cycle; the counter is held at 0.
- linha_tx is registered and glitch-free. palavra holds its value until the next acceptance.

Decomposition:
- Shared package hamming_pkg holds:
  - constants LARG_DADO=11, LARG_PALAVRA=15;
  - the data-to-codeword index map;
  - the four parity index lists;
  - the state enum {OCIOSO, START, DADOS, STOP}.
- One natural sub-module: codifica_hamming, a purely combinational 11->15 encoder, reused by the corrector testbench as its golden model.
- The FSM, counters and shift register stay in the top module.

Test Plan:
- Reset then idle: rst_n low 3 cycles, released -> pronto=1, linha_tx=1, palavra=15'h0000 held for 20 cycles.
- Encode checks with CICLOS_POR_BIT=4 and injeta_erro=0:
  - dado=11'h001 -> palavra=15'h0007;
  - dado=11'h400 -> palavra=15'h408B;
  - dado=11'h7FF -> palavra=15'h7FFF;
  - dado=11'h000 -> palavra=15'h0000.
- Frame timing: dado=11'h001 -> linha_tx low 4 cycles after acceptance, then bits 1,1,1,0,...,0 each 4 cycles, then high 4 cycles. pronto returns exactly 68 cycles after acceptance.
- Injection: dado=11'h001, injeta_erro=4'd15 -> palavra=15'h4007; serial bit 14 is 1. Feeding palavra to the corrector returns saida=11'h001.
- Busy and back-to-back: dado_valido held high with new data during a frame -> no change to palavra until pronto. The second frame's start bit begins 1 cycle after the first stop ends.
- Reset mid-frame: rst_n low during DADOS bit 7 -> linha_tx=1 and pronto=1 without waiting for a clock edge. The next transfer after release sends a complete, correct frame.
